mips_muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS core. It adds MULT, MULTU, DIV, DIVU, MTHI and MTLO with architectural HI/LO registers, which the single-cycle ALU does not support. The width is parametrised, and each operation takes a fixed, deterministic latency. It sits beside the ALU in the datapath: the controller issues with a start pulse, stalls on busy, and reads HI/LO for MFHI/MFLO.

---
 rtl/mips_muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring shift-subtract.
// Both run on operand magnitudes, and the sign is corrected in the FIX state.
// Latency from the issue edge to the rising edge of done is WIDTH+2 edges.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk_w,
  input  logic             i_rst_w,
  input  logic             i_start_w,
  input  logic [2:0]       i_op_w,
  input  logic [WIDTH-1:0] i_a_w,
  input  logic [WIDTH-1:0] i_b_w,
  output logic             o_busy_w,
  output logic             o_done_w,
  output logic [WIDTH-1:0] o_hi_w,
  output logic [WIDTH-1:0] o_lo_w,
  output logic             o_div_by_zero_w
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // {HI-half, LO-half}: product, or {remainder, quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_q, a_d;         // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               dz_q, dz_d;       // pending divide-by-zero of the op in flight
  logic               dbz_q, dbz_d;     // architectural flag

  // Conditional two's-complement negation
  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic en);
    cneg_w = en ? (~v + ONE_W) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    cneg_2w = en ? (~v + ONE_2W) : v;
  endfunction

  // Issue-time sign extraction and magnitudes (signed ops have op[0] == 0)
  logic             iss_sa, iss_sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign iss_sa = i_a_w[WIDTH-1] & ~i_op_w[0];
  assign iss_sb = i_b_w[WIDTH-1] & ~i_op_w[0];
  assign mag_a  = cneg_w(i_a_w, iss_sa);
  assign mag_b  = cneg_w(i_b_w, iss_sb);

  // One shift-add multiply step: conditionally add the multiplicand to the upper half, then shift right
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring divide step: shift the next dividend bit into the remainder and subtract if it fits
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_fit;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_fit   = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  assign div_next  = div_fit ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                             : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (i_start_w) begin
          if (!i_op_w[2]) begin
            state_d  = RUN;
            cnt_d    = CW'(WIDTH);
            is_div_d = i_op_w[1];
            sa_d     = iss_sa;
            sb_d     = iss_sb;
            a_d      = i_a_w;
            acc_d    = {{WIDTH{1'b0}}, (i_op_w[1] ? mag_a : mag_b)};
            opnd_d   = i_op_w[1] ? mag_b : mag_a;
            dz_d     = i_op_w[1] && (i_b_w == '0);
            dbz_d    = 1'b0;
          end else if (!i_op_w[1]) begin
            if (i_op_w[0]) lo_d = i_a_w;
            else           hi_d = i_a_w;
          end
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          acc_d = is_div_q ? div_next : mul_next;
        end else begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = DONE;
        dbz_d   = dz_q;
        if (!is_div_q) begin
          {hi_d, lo_d} = cneg_2w(acc_q, sa_q ^ sb_q);
        end else if (dz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          lo_d = cneg_w(acc_q[WIDTH-1:0], sa_q ^ sb_q);
          hi_d = cneg_w(acc_q[2*WIDTH-1:WIDTH], sa_q);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and architectural registers, cleared by reset
  always_ff @(posedge i_clk_w) begin
    if (!i_rst_w) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working datapath registers, only meaningful after an accepted issue
  always_ff @(posedge i_clk_w) begin
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    a_q      <= a_d;
    is_div_q <= is_div_d;
    sa_q     <= sa_d;
    sb_q     <= sb_d;
  end

  assign o_busy_w        = (state_q == RUN) || (state_q == FIX);
  assign o_done_w        = (state_q == DONE);
  assign o_hi_w          = hi_q;
  assign o_lo_w          = lo_q;
  assign o_div_by_zero_w = dbz_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, start8;
  logic [2:0]  op;
  logic [31:0] a, b;

  logic        busy32, done32, dbz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32)) dut32 (
    .i_clk_w(clk), .i_rst_w(rst), .i_start_w(start32), .i_op_w(op),
    .i_a_w(a), .i_b_w(b), .o_busy_w(busy32), .o_done_w(done32),
    .o_hi_w(hi32), .o_lo_w(lo32), .o_div_by_zero_w(dbz32)
  );

  mips_muldiv_unit #(.WIDTH(8)) dut8 (
    .i_clk_w(clk), .i_rst_w(rst), .i_start_w(start8), .i_op_w(op),
    .i_a_w(a[7:0]), .i_b_w(b[7:0]), .o_busy_w(busy8), .o_done_w(done8),
    .o_hi_w(hi8), .o_lo_w(lo8), .o_div_by_zero_w(dbz8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one mul/div on the selected instance, scramble operands, then check latency and results
  task automatic run_op(input bit w8, input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] ehi, input logic [31:0] elo, input bit edz, input string tag);
    int n;
    @(negedge clk);
    op = o; a = va; b = vb;
    if (w8) start8 = 1'b1; else start32 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    a = $urandom; b = $urandom;
    chk({tag, " busy"}, w8 ? busy8 : busy32, 1'b1);
    chk({tag, " dbz clr"}, w8 ? dbz8 : dbz32, 1'b0);
    n = 0;
    while (!(w8 ? done8 : done32) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, w8 ? 10 : 34);
    chk({tag, " hi"}, w8 ? {24'b0, hi8} : hi32, ehi);
    chk({tag, " lo"}, w8 ? {24'b0, lo8} : lo32, elo);
    chk({tag, " dbz"}, w8 ? dbz8 : dbz32, edz);
    chk({tag, " busy@done"}, w8 ? busy8 : busy32, 1'b0);
    @(posedge clk); #1;
    chk({tag, " done pulse"}, w8 ? done8 : done32, 1'b0);
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b0; start32 = 1'b0; start8 = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy32, 1'b0);
    chk("rst done", done32, 1'b0);
    chk("rst hi", hi32, 32'h0);
    chk("rst lo", lo32, 32'h0);
    chk("rst dbz", dbz32, 1'b0);
    chk("rst8 hilo", {hi8, lo8}, 16'h0);
    @(negedge clk); rst = 1'b1;

    // WIDTH = 32 directed set
    run_op(0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, "multu max");
    run_op(0, 3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, "mult -3*7");
    run_op(0, 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, "mult minneg^2");
    run_op(0, 3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, "div -7/2");
    run_op(0, 3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 0, "divu 7/2");
    run_op(0, 3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, "div 7/-2");
    run_op(0, 3'b011, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1, "divu 5/0");
    repeat (3) @(posedge clk);
    #1;
    chk("dbz hold", dbz32, 1'b1);
    run_op(0, 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, "div minneg/-1");

    // MTLO / MTHI from IDLE
    @(negedge clk); op = 3'b101; a = 32'h1234; start32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0;
    chk("mtlo lo", lo32, 32'h1234);
    chk("mtlo hi kept", hi32, 32'h0);
    chk("mtlo busy", busy32, 1'b0);
    @(posedge clk); #1;
    chk("mtlo done", done32, 1'b0);
    @(negedge clk); op = 3'b100; a = 32'h55; start32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0;
    chk("mthi hi", hi32, 32'h55);
    @(negedge clk); op = 3'b110; a = 32'h77; start32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0;
    chk("noop busy", busy32, 1'b0);
    chk("noop hilo", {hi32, lo32}, {32'h55, 32'h1234});

    // Starts while busy are ignored
    @(negedge clk); op = 3'b001; a = 32'd3; b = 32'd4; start32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); op = 3'b100; a = 32'hAA; start32 = 1'b1;
    @(posedge clk); #1;
    chk("busy mthi ignored", hi32, 32'h55);
    @(negedge clk); op = 3'b011; a = 32'd100; b = 32'd7; start32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0;
    n = 6;
    while (!done32 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ignored latency", n, 34);
    chk("ignored hi", hi32, 32'h0);
    chk("ignored lo", lo32, 32'd12);
    @(posedge clk); #1;
    chk("ignored no 2nd op", busy32, 1'b0);

    // Reset in the middle of a run
    run_op(0, 3'b011, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 0, "divu 100/7");
    @(negedge clk); op = 3'b001; a = 32'd9; b = 32'd9; start32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst busy", busy32, 1'b0);
    chk("midrst hi", hi32, 32'h0);
    chk("midrst lo", lo32, 32'h0);
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done32 || busy32) seen = 1'b1;
    end
    chk("midrst no done", seen, 1'b0);
    run_op(0, 3'b001, 32'd2, 32'd3, 32'h0, 32'd6, 0, "multu 2*3");

    // WIDTH = 8 directed set
    run_op(1, 3'b001, 32'hFF, 32'hFF, 32'hFE, 32'h01, 0, "w8 multu max");
    run_op(1, 3'b000, 32'hFD, 32'h07, 32'hFF, 32'hEB, 0, "w8 mult -3*7");
    run_op(1, 3'b000, 32'h80, 32'h80, 32'h40, 32'h00, 0, "w8 mult minneg^2");
    run_op(1, 3'b010, 32'hF9, 32'h02, 32'hFF, 32'hFD, 0, "w8 div -7/2");
    run_op(1, 3'b011, 32'h07, 32'h02, 32'h01, 32'h03, 0, "w8 divu 7/2");
    run_op(1, 3'b010, 32'h07, 32'hFE, 32'h01, 32'hFD, 0, "w8 div 7/-2");
    run_op(1, 3'b011, 32'h05, 32'h00, 32'h05, 32'hFF, 1, "w8 divu 5/0");
    run_op(1, 3'b010, 32'h80, 32'hFF, 32'h00, 32'h80, 0, "w8 div minneg/-1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
